csi_payload_crc_check: RTL

Checks the CRC-16 of CSI-2 long-packet payloads in the receive path. It sits after the lane merger and packet-header decoder, and before the pixel unpacker. It accepts a 4-byte-per-cycle payload stream with the header word count, computes the CSI-2 CRC over exactly WC bytes, and captures the 2 trailing checksum bytes. It then reports one pass/fail result per packet.

---
 rtl/csi_pkg.sv | 30 +++
 rtl/csi_crc16_byte_step.sv | 33 +++
 rtl/csi_payload_crc_check.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/csi_pkg.sv
// Shared CSI-2 receive definitions: FSM states, CRC-16 constants, byte-step helper.
// Latency: none (definitions only).
// Backpressure: not applicable.
package csi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CKSUM,
        ST_REPORT
    } csi_state_e;

    localparam logic [15:0] CSI_CRC_POLY = 16'h8408;
    localparam logic [15:0] CSI_CRC_SEED = 16'hFFFF;

    // Reflected CRC-16: byte consumed LSB first, no final XOR.
    function automatic logic [15:0] csi_crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] r;
        r = crc;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) begin
                r = (r >> 1) ^ CSI_CRC_POLY;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/csi_crc16_byte_step.sv
// Advances a CSI-2 CRC-16 over the first cnt_i bytes (lane 0 first) of a 4-byte word.
// Latency: combinational.
// Backpressure: none; cnt_i of 0 passes the CRC through unchanged.
module csi_crc16_byte_step
    import csi_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  cnt_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_1;
    logic [15:0] crc_2;
    logic [15:0] crc_3;
    logic [15:0] crc_4;

    assign crc_1 = csi_crc16_byte(crc_i, data_i[7:0]);
    assign crc_2 = csi_crc16_byte(crc_1, data_i[15:8]);
    assign crc_3 = csi_crc16_byte(crc_2, data_i[23:16]);
    assign crc_4 = csi_crc16_byte(crc_3, data_i[31:24]);

    always_comb begin
        case (cnt_i)
            3'd1:    crc_o = crc_1;
            3'd2:    crc_o = crc_2;
            3'd3:    crc_o = crc_3;
            3'd4:    crc_o = crc_4;
            default: crc_o = crc_i;
        endcase
    end

endmodule

// File: rtl/csi_payload_crc_check.sv
// Checks CSI-2 long-packet payload CRC-16 against the trailing checksum, one result per packet.
// Latency: result strobe 1 cycle after the beat carrying the second checksum byte.
// Backpressure: none; accepts one beat per cycle, a new header aborts the packet in flight.
module csi_payload_crc_check
    import csi_pkg::*;
#(
    parameter logic [15:0] SEED = CSI_CRC_SEED
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        hdr_valid_i,
    input  logic [15:0] word_count_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_i,
    output logic        busy_o,
    output logic        crc_valid_o,
    output logic        crc_ok_o,
    output logic [15:0] crc_calc_o,
    output logic [15:0] crc_rx_o,
    output logic        abort_o
);

    csi_state_e  state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] crc_q, crc_d;
    logic [1:0]  ck_cnt_q, ck_cnt_d;
    logic [15:0] rx_q, rx_d;
    logic        crc_valid_q, crc_valid_d;
    logic        crc_ok_q, crc_ok_d;
    logic [15:0] crc_calc_q, crc_calc_d;
    logic [15:0] crc_rx_q, crc_rx_d;
    logic        abort_q, abort_d;

    logic [2:0]  n_bytes;
    logic [2:0]  step_cnt;
    logic [2:0]  first_ck_lane;
    logic [15:0] step_crc;
    logic [1:0]  cap_cnt;
    logic [15:0] cap_rx;

    assign n_bytes  = (rem_q > 16'd3) ? 3'd4 : rem_q[2:0];
    assign step_cnt = (state_q == ST_PAYLOAD) ? n_bytes : 3'd0;
    // Payload beats carry checksum only in lanes past the last payload byte.
    assign first_ck_lane = (state_q == ST_PAYLOAD) ? n_bytes : 3'd0;

    csi_crc16_byte_step u_step (
        .crc_i  (crc_q),
        .data_i (data_i),
        .cnt_i  (step_cnt),
        .crc_o  (step_crc)
    );

    always_comb begin
        cap_cnt = ck_cnt_q;
        cap_rx  = rx_q;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) >= first_ck_lane && cap_cnt < 2'd2) begin
                if (cap_cnt == 2'd0) begin
                    cap_rx[7:0] = data_i[8*i +: 8];
                end else begin
                    cap_rx[15:8] = data_i[8*i +: 8];
                end
                cap_cnt = cap_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        crc_d       = crc_q;
        ck_cnt_d    = ck_cnt_q;
        rx_d        = rx_q;
        crc_valid_d = 1'b0;
        crc_ok_d    = crc_ok_q;
        crc_calc_d  = crc_calc_q;
        crc_rx_d    = crc_rx_q;
        abort_d     = 1'b0;

        if (hdr_valid_i) begin
            // Any beat in the same cycle belongs to the dropped context.
            abort_d  = (state_q != ST_IDLE);
            rem_d    = word_count_i;
            crc_d    = SEED;
            ck_cnt_d = 2'd0;
            state_d  = (word_count_i != 16'd0) ? ST_PAYLOAD : ST_CKSUM;
        end else begin
            case (state_q)
                ST_PAYLOAD: begin
                    if (data_valid_i) begin
                        crc_d    = step_crc;
                        rem_d    = rem_q - {13'd0, n_bytes};
                        ck_cnt_d = cap_cnt;
                        rx_d     = cap_rx;
                        if (rem_d == 16'd0) begin
                            state_d = (cap_cnt == 2'd2) ? ST_REPORT : ST_CKSUM;
                        end
                    end
                end
                ST_CKSUM: begin
                    if (data_valid_i) begin
                        ck_cnt_d = cap_cnt;
                        rx_d     = cap_rx;
                        if (cap_cnt == 2'd2) begin
                            state_d = ST_REPORT;
                        end
                    end
                end
                ST_REPORT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase

            // Result is registered on entry to REPORT so the strobe coincides with that state.
            if (state_d == ST_REPORT && state_q != ST_REPORT) begin
                crc_valid_d = 1'b1;
                crc_calc_d  = crc_d;
                crc_rx_d    = cap_rx;
                crc_ok_d    = (crc_d == cap_rx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            rem_q       <= 16'd0;
            crc_q       <= SEED;
            ck_cnt_q    <= 2'd0;
            rx_q        <= 16'd0;
            crc_valid_q <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_calc_q  <= 16'd0;
            crc_rx_q    <= 16'd0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            crc_q       <= crc_d;
            ck_cnt_q    <= ck_cnt_d;
            rx_q        <= rx_d;
            crc_valid_q <= crc_valid_d;
            crc_ok_q    <= crc_ok_d;
            crc_calc_q  <= crc_calc_d;
            crc_rx_q    <= crc_rx_d;
            abort_q     <= abort_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign crc_valid_o = crc_valid_q;
    assign crc_ok_o    = crc_ok_q;
    assign crc_calc_o  = crc_calc_q;
    assign crc_rx_o    = crc_rx_q;
    assign abort_o     = abort_q;

endmodule
